tmds_encoder_multi: RTL and testbench
=====================================

Name: tmds_encoder_multi

Overview:
- Parametrised, pipelined TMDS 8b/10b encoder for NUM_CH lanes, running entirely in the pixel clock domain.
- Successor to the fixed 3-lane DVI encoder: lane count, control-lane mapping and clock-enable are generalised.
- Per-lane running disparity is tracked explicitly.
- Produces 10-bit symbols per lane for the downstream OSERDES serializers in the HDMI output path.

Parameters:
- NUM_CH, 3, number of TMDS data lanes.
- BAR_SHIFT, 7, log2 of test-pattern bar width in pixels (used only with the optional feature).

Ports:
- clk_pixel  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  pipeline advance enable; when 0 the whole pipeline holds.
- blank  in  1  1 = control period, 0 = video data period.
- pixel  in  8*NUM_CH  lane c data at bits [8c+7:8c].
- ctrl  in  2*NUM_CH  lane c control {C1,C0} at bits [2c+1:2c]; for DVI, lane 0 carries {vsync,hsync}.
- sym  out  10*NUM_CH  lane c symbol at bits [10c+9:10c]; bit 0 is transmitted first.
- sym_valid  out  1  ce delayed through the pipeline.

Behaviour:
- Reset (synchronous, active-high):
  - every lane's sym = 10'b1101010100 (control token for C=00);
  - disparity counters = 0;
  - sym_valid = 0;
  - all pipeline registers cleared, with blank held as 1.
- Pipeline: 3 stages, fixed latency 3 ce-qualified cycles from input to sym. When ce=0, all stage registers, disparity and sym hold.
- sym_valid: register chain of ce, depth 3; it does not hold when ce=0.
- Stage 1: register pixel, ctrl and blank. Compute n1 = popcount(D), 4-bit.
- Stage 2: build q_m[8:0].
  - Use the XNOR path if n1>4, or if n1==4 and D[0]==0. Otherwise use the XOR path.
  - q_m[0] = D[0]; q_m[i] = q_m[i-1] op D[i]; q_m[8] = 1 for XOR, 0 for XNOR.
  - Register n1q/n0q = ones/zeros count of q_m[7:0].
- Stage 3, disparity cnt (5-bit signed two's complement, per lane):
  - Case cnt==0 or n1q==n0q:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
    - cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
  - Else case (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - out = {1, q_m[8], ~q_m[7:0]};
    - cnt += 2*q_m[8] + (n0q-n1q).
  - Otherwise:
    - out = {0, q_m[8], q_m[7:0]};
    - cnt += (n1q-n0q) - 2*(~q_m[8]).
- Blank in stage 3:
  - sym = control token: C=00 → 1101010100, 01 → 0010101011, 10 → 0101010100, 11 → 1010101011;
  - cnt forced to 0 that cycle.
- Blank/data transitions: apply per-cycle with no gap. The first data symbol after blank always sees cnt=0.
- Lanes are fully independent; disparity never crosses lanes.

Optional Feature:
- Macro: TMDS_TESTPAT_EN.
- With the macro defined:
  - extra input test_en (1 bit) and an internal 12-bit column counter;
  - counter is cleared on reset or when ce && blank, increments on ce && !blank, and wraps at 4095;
  - when test_en=1 and blank=0, stage 1 replaces lane c data with 8'hFF if bit (c mod 3) of col[BAR_SHIFT+2:BAR_SHIFT] is set, else 8'h00;
  - this gives 8 colour bars, with latency unchanged.
- Without the macro: no test_en port, no counter, pixel passes straight through.

Decomposition:
- Package tmds_pkg:
  - the four control-token constants;
  - popcount8 function;
  - disparity width localparam (5).
- Sub-module tmds_lane: one-lane 3-stage encoder with its own cnt. Instantiated NUM_CH times via generate.
- Top level contains:
  - port slicing;
  - sym_valid chain;
  - optional test-pattern counter.

Test Plan:
- Reset: assert reset 2 cycles with ce=1 → all sym = 10'h354, sym_valid=0. sym_valid rises 3 cycles after reset release.
- Blank=1 with lane-0 ctrl cycling 00,01,10,11 → 3 cycles later lane-0 sym = 10'h354, 10'h0AB, 10'h154, 10'h2AB.
- Leave blank, pixel lane 0 = 8'h00 twice → sym 10'h100 (cnt→-8), then 10'h3FF (cnt→+2).
- Leave blank, pixel = 8'hFF once → sym 10'h200, cnt=-8. Then blank=1 → control token and cnt=0. Then 8'hFF again → 10'h200 again.
- Drop ce for 5 cycles mid-stream → sym and cnt frozen. Resuming yields exactly the ce-compressed sequence of the ungated run. Randomised data checked against a reference model with |cnt| ≤ 8 for 10k symbols.
- With TMDS_TESTPAT_EN, NUM_CH=3, BAR_SHIFT=2, test_en=1 → data column 0 gives all lanes 8'h00 encoded; column 4 gives lane 0 8'hFF; column 28 gives all lanes 8'hFF.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the multi-lane TMDS encoder.
// Holds the control tokens, the disparity counter width and a byte popcount.
package tmds_pkg;

    localparam int CNT_W = 5;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: 3-stage 8b/10b encoder with its own running disparity.
// Stage 1 registers inputs, stage 2 builds q_m, stage 3 balances DC and emits the symbol.
module tmds_lane
    import tmds_pkg::*;
(
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       ce,
    input  logic       blank,
    input  logic [7:0] pixel,
    input  logic [1:0] ctrl,
    output logic [9:0] sym
);

    logic [7:0]              r_d1;
    logic [1:0]              r_c1;
    logic                    r_b1;

    logic [8:0]              r_qm;
    logic [3:0]              r_n1q;
    logic [3:0]              r_n0q;
    logic [1:0]              r_c2;
    logic                    r_b2;

    logic signed [CNT_W-1:0] r_cnt;
    logic [9:0]              r_sym;

    logic [3:0]              w_n1;
    logic                    w_xnor;
    logic [8:0]              w_qm;
    logic signed [CNT_W-1:0] w_diff;
    logic signed [CNT_W-1:0] w_cntNext;
    logic [9:0]              w_symNext;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_d1 <= '0;
            r_c1 <= '0;
            r_b1 <= 1'b1;
        end else if (ce) begin
            r_d1 <= pixel;
            r_c1 <= ctrl;
            r_b1 <= blank;
        end
    end

    // Pick the transition-minimising chain: XNOR when the byte is ones-heavy.
    assign w_n1   = popcount8(r_d1);
    assign w_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !r_d1[0]);

    always_comb begin
        logic [8:0] v;
        v    = '0;
        v[0] = r_d1[0];
        for (int i = 1; i < 8; i++) begin
            v[i] = w_xnor ? ~(v[i-1] ^ r_d1[i]) : (v[i-1] ^ r_d1[i]);
        end
        v[8] = ~w_xnor;
        w_qm = v;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_qm  <= '0;
            r_n1q <= '0;
            r_n0q <= '0;
            r_c2  <= '0;
            r_b2  <= 1'b1;
        end else if (ce) begin
            r_qm  <= w_qm;
            r_n1q <= popcount8(w_qm[7:0]);
            r_n0q <= 4'd8 - popcount8(w_qm[7:0]);
            r_c2  <= r_c1;
            r_b2  <= r_b1;
        end
    end

    assign w_diff = $signed({1'b0, r_n1q}) - $signed({1'b0, r_n0q});

    // Invert the payload whenever that steers the running disparity back toward zero.
    always_comb begin
        w_symNext = r_sym;
        w_cntNext = r_cnt;
        if (r_b2) begin
            w_cntNext = '0;
            case (r_c2)
                2'b00:   w_symNext = TOK_C00;
                2'b01:   w_symNext = TOK_C01;
                2'b10:   w_symNext = TOK_C10;
                default: w_symNext = TOK_C11;
            endcase
        end else if ((r_cnt == 5'sd0) || (r_n1q == r_n0q)) begin
            w_symNext = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cntNext = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if (((r_cnt > 5'sd0) && (r_n1q > r_n0q)) ||
                     ((r_cnt < 5'sd0) && (r_n0q > r_n1q))) begin
            w_symNext = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cntNext = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
        end else begin
            w_symNext = {1'b0, r_qm[8], r_qm[7:0]};
            w_cntNext = r_cnt + w_diff - (r_qm[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_sym <= TOK_C00;
            r_cnt <= '0;
        end else if (ce) begin
            r_sym <= w_symNext;
            r_cnt <= w_cntNext;
        end
    end

    assign sym = r_sym;

endmodule

// File: rtl/tmds_encoder_multi.sv
// NUM_CH-lane TMDS encoder top: lane slicing, sym_valid chain, optional colour-bar source.
// Define TMDS_TESTPAT_EN to add the test_en input and the column-counter bar generator.
module tmds_encoder_multi
    import tmds_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int BAR_SHIFT = 7
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  blank,
    input  logic [8*NUM_CH-1:0]   pixel,
    input  logic [2*NUM_CH-1:0]   ctrl,
`ifdef TMDS_TESTPAT_EN
    input  logic                  test_en,
`endif
    output logic [10*NUM_CH-1:0]  sym,
    output logic                  sym_valid
);

    // The bar index slice must fit inside the 12-bit column counter.
    if (BAR_SHIFT < 0 || BAR_SHIFT + 3 > 12) begin : g_badShift
        $error("BAR_SHIFT out of range");
    end

    logic [2:0] r_vld;

    // Valid tracks ce through the pipe and keeps shifting even while ce is low.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[1:0], ce};
        end
    end

    assign sym_valid = r_vld[2];

`ifdef TMDS_TESTPAT_EN
    logic [11:0] r_col;
    logic [2:0]  w_bars;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_col <= '0;
        end else if (ce) begin
            r_col <= blank ? 12'd0 : r_col + 12'd1;
        end
    end

    assign w_bars = r_col[BAR_SHIFT+2:BAR_SHIFT];
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic [7:0] w_pix;

`ifdef TMDS_TESTPAT_EN
        assign w_pix = (test_en && !blank) ? (w_bars[c % 3] ? 8'hFF : 8'h00)
                                           : pixel[8*c +: 8];
`else
        assign w_pix = pixel[8*c +: 8];
`endif

        tmds_lane u_lane (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .ce        (ce),
            .blank     (blank),
            .pixel     (w_pix),
            .ctrl      (ctrl[2*c +: 2]),
            .sym       (sym[10*c +: 10])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Self-checking bench for tmds_encoder_multi: hand-computed vector table plus
// a ce-gated random stream compared against a behavioural encoder.
module tb_tmds_encoder_multi;

    localparam int NCH = 3;

    logic              clk;
    logic              reset;
    logic              ce;
    logic              blank;
    logic [8*NCH-1:0]  pixel;
    logic [2*NCH-1:0]  ctrl;
    logic [10*NCH-1:0] sym;
    logic              symValid;
`ifdef TMDS_TESTPAT_EN
    logic              testEn;
`endif

    int checkCount;
    int errorCount;

    typedef struct {
        logic       blank;
        logic [1:0] ctrl;
        logic [7:0] pix;
        logic [9:0] expSym;
    } vec_t;

    vec_t vecs[21];

    tmds_encoder_multi #(.NUM_CH(NCH), .BAR_SHIFT(7)) dut (
        .clk_pixel (clk),
        .reset     (reset),
        .ce        (ce),
        .blank     (blank),
        .pixel     (pixel),
        .ctrl      (ctrl),
`ifdef TMDS_TESTPAT_EN
        .test_en   (testEn),
`endif
        .sym       (sym),
        .sym_valid (symValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the same byte on every lane; only lane 0 gets the requested control bits.
    task automatic applyStimulus(input logic b, input logic [1:0] c, input logic [7:0] d);
        blank = b;
        ctrl  = {4'b0000, c};
        pixel = {NCH{d}};
    endtask

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural encoder, one symbol per call, disparity carried by the caller.
    function automatic logic [9:0] refEncode(input logic [7:0] d, input logic b,
                                             input logic [1:0] c, inout int cnt);
        logic [8:0] q;
        int         ones;
        int         n1;
        int         n0;
        logic [9:0] r;
        if (b) begin
            cnt = 0;
            case (c)
                2'd0:    return 10'h354;
                2'd1:    return 10'h0AB;
                2'd2:    return 10'h154;
                default: return 10'h2AB;
            endcase
        end
        ones = $countones(d);
        q    = '0;
        q[0] = d[0];
        if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ~^ d[i];
            q[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
            q[8] = 1'b1;
        end
        n1 = $countones(q[7:0]);
        n0 = 8 - n1;
        if (cnt == 0 || n1 == n0) begin
            r   = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt = cnt + (q[8] ? (n1 - n0) : (n0 - n1));
        end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
            r   = {1'b1, q[8], ~q[7:0]};
            cnt = cnt + 2 * int'(q[8]) + (n0 - n1);
        end else begin
            r   = {1'b0, q[8], q[7:0]};
            cnt = cnt + (n1 - n0) - 2 * int'(!q[8]);
        end
        return r;
    endfunction

    initial begin
        int         mCnt[NCH];
        logic [9:0] expQ[NCH][$];
        logic [9:0] curExp[NCH];
        logic [2:0] vHist;
        logic [9:0] e;
        logic [7:0] rp;
        logic [1:0] rc;
        logic       rb;

        checkCount = 0;
        errorCount = 0;
`ifdef TMDS_TESTPAT_EN
        testEn = 1'b0;
`endif

        vecs[0]  = '{1'b1, 2'd0, 8'h00, 10'h354};
        vecs[1]  = '{1'b1, 2'd1, 8'h00, 10'h0AB};
        vecs[2]  = '{1'b1, 2'd2, 8'h00, 10'h154};
        vecs[3]  = '{1'b1, 2'd3, 8'h00, 10'h2AB};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 10'h100};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 10'h3FF};
        vecs[6]  = '{1'b1, 2'd0, 8'h00, 10'h354};
        vecs[7]  = '{1'b0, 2'd0, 8'hFF, 10'h200};
        vecs[8]  = '{1'b1, 2'd0, 8'h00, 10'h354};
        vecs[9]  = '{1'b0, 2'd0, 8'hFF, 10'h200};
        vecs[10] = '{1'b0, 2'd0, 8'h55, 10'h133};
        vecs[11] = '{1'b0, 2'd0, 8'h01, 10'h1FF};
        vecs[12] = '{1'b0, 2'd0, 8'h10, 10'h1F0};
        vecs[13] = '{1'b0, 2'd0, 8'h0F, 10'h105};
        vecs[14] = '{1'b0, 2'd0, 8'h0F, 10'h3FA};
        vecs[15] = '{1'b0, 2'd0, 8'hFE, 10'h000};
        vecs[16] = '{1'b0, 2'd0, 8'hFE, 10'h2FF};
        vecs[17] = '{1'b0, 2'd0, 8'h08, 10'h1F8};
        vecs[18] = '{1'b0, 2'd0, 8'h08, 10'h307};
        vecs[19] = '{1'b0, 2'd0, 8'hF0, 10'h205};
        vecs[20] = '{1'b1, 2'd1, 8'h00, 10'h0AB};

        // Reset held two cycles with ce high.
        reset = 1'b1;
        ce    = 1'b1;
        applyStimulus(1'b1, 2'd0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) checkOutput($sformatf("reset sym lane%0d", c), sym[10*c +: 10], 10'h354);
        checkOutput("reset sym_valid", {9'b0, symValid}, 10'd0);

        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("sym_valid %0d after release", k), {9'b0, symValid},
                        (k == 3) ? 10'd1 : 10'd0);
        end

        // Vector table: sym of vector i appears after the edge two iterations later.
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (i < 21) applyStimulus(vecs[i].blank, vecs[i].ctrl, vecs[i].pix);
            else        applyStimulus(1'b1, 2'd0, 8'h00);
            @(posedge clk);
            #1;
            if (i >= 2) begin
                checkOutput($sformatf("vec%0d lane0", i - 2), sym[9:0], vecs[i-2].expSym);
                for (int c = 1; c < NCH; c++)
                    checkOutput($sformatf("vec%0d lane%0d", i - 2, c), sym[10*c +: 10],
                                vecs[i-2].blank ? 10'h354 : vecs[i-2].expSym);
                checkOutput($sformatf("vec%0d sym_valid", i - 2), {9'b0, symValid}, 10'd1);
            end
        end

        // Random stream with a 5-cycle ce drop and sporadic ce gaps, fresh from reset.
        @(negedge clk);
        reset = 1'b1;
        ce    = 1'b1;
        applyStimulus(1'b1, 2'd0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vHist = '0;
        for (int c = 0; c < NCH; c++) begin
            mCnt[c]   = 0;
            curExp[c] = 10'h354;
            expQ[c].delete();
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clk);
            ce = !((cyc >= 40 && cyc < 45) || ($urandom_range(0, 9) == 0));
            rb = ($urandom_range(0, 11) == 0);
            for (int c = 0; c < NCH; c++) begin
                rp = 8'($urandom_range(0, 255));
                rc = 2'($urandom_range(0, 3));
                pixel[8*c +: 8] = rp;
                ctrl[2*c +: 2]  = rc;
            end
            blank = rb;
            if (ce) begin
                for (int c = 0; c < NCH; c++) begin
                    e = refEncode(pixel[8*c +: 8], rb, ctrl[2*c +: 2], mCnt[c]);
                    expQ[c].push_back(e);
                    if (expQ[c].size() == 3) curExp[c] = expQ[c].pop_front();
                end
            end
            vHist = {vHist[1:0], ce};
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++)
                checkOutput($sformatf("rand cyc%0d lane%0d", cyc, c), sym[10*c +: 10], curExp[c]);
            checkOutput($sformatf("rand cyc%0d sym_valid", cyc), {9'b0, symValid}, {9'b0, vHist[2]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
